// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the pipeline control state type.
package y86_pkg;

  localparam logic [3:0] IcHalt  = 4'h0;
  localparam logic [3:0] IcNop   = 4'h1;
  localparam logic [3:0] IcCmov  = 4'h2;
  localparam logic [3:0] IcIrmov = 4'h3;
  localparam logic [3:0] IcRmmov = 4'h4;
  localparam logic [3:0] IcMrmov = 4'h5;
  localparam logic [3:0] IcOpq   = 4'h6;
  localparam logic [3:0] IcJxx   = 4'h7;
  localparam logic [3:0] IcCall  = 4'h8;
  localparam logic [3:0] IcRet   = 4'h9;
  localparam logic [3:0] IcPush  = 4'hA;
  localparam logic [3:0] IcPop   = 4'hB;

  localparam logic [1:0] StatAok = 2'd0;
  localparam logic [1:0] StatHlt = 2'd1;
  localparam logic [1:0] StatAdr = 2'd2;
  localparam logic [1:0] StatIns = 2'd3;

  localparam logic [3:0] RegNone = 4'hF;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] countQ, countD;

  always_comb begin
    countD = countQ;
    if (clr) begin
      countD = '0;
    end else if (inc && (countQ != '1)) begin
      countD = countQ + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      countQ <= '0;
    end else begin
      countQ <= countD;
    end
  end

  assign count = countQ;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline control: hazard stall/bubble decode, exception shutdown sequencing,
// saturating performance counters and a stall watchdog.
module pipe_hazard_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned STALL_LIMIT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic             e_Cnd,
  input  logic [1:0]       m_stat,
  input  logic [1:0]       W_stat,
  input  logic [3:0]       W_icode,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic [1:0]       state,
  output logic [1:0]       final_stat,
  output logic             hang_flag,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [CNT_W-1:0] HangAt = CNT_W'(STALL_LIMIT - 1);

  state_e     stateQ, stateD;
  logic [1:0] finalStatQ, finalStatD;
  logic       hangQ, hangD;
  logic [CNT_W-1:0] runCnt;

  logic loadUse, retP, misPred, exc, halted;

  assign loadUse = ((E_icode == IcMrmov) || (E_icode == IcPop)) && (E_dstM != RegNone) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign retP    = (D_icode == IcRet) || (E_icode == IcRet) || (M_icode == IcRet);
  assign misPred = (E_icode == IcJxx) && !e_Cnd;
  assign exc     = (m_stat != StatAok) || (W_stat != StatAok);
  assign halted  = (stateQ == StHalted);

  // Load/use wins over ret so D is held rather than both held and bubbled.
  always_comb begin
    F_stall  = loadUse | retP;
    D_stall  = loadUse;
    D_bubble = misPred | (retP & ~loadUse);
    E_bubble = misPred | loadUse;
    M_bubble = exc;
    W_stall  = (W_stat != StatAok);
    set_cc   = (E_icode == IcOpq) && !exc;
    if (halted) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      D_bubble = 1'b0;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b1;
      set_cc   = 1'b0;
    end
  end

  always_comb begin
    stateD     = stateQ;
    finalStatD = finalStatQ;
    case (stateQ)
      StRun: begin
        if (W_stat != StatAok) begin
          stateD     = StHalted;
          finalStatD = W_stat;
        end else if (m_stat != StatAok) begin
          stateD = StDrain;
        end
      end
      StDrain: begin
        if (W_stat != StatAok) begin
          stateD     = StHalted;
          finalStatD = W_stat;
        end else if (m_stat == StatAok) begin
          // Faulting instruction was squashed before reaching W.
          stateD = StRun;
        end
      end
      StHalted: ;
      default: stateD = StRun;
    endcase
  end

  assign hangD = hangQ | ((stateQ == StRun) && F_stall && (runCnt >= HangAt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ     <= StRun;
      finalStatQ <= StatAok;
      hangQ      <= 1'b0;
    end else begin
      stateQ     <= stateD;
      finalStatQ <= finalStatD;
      hangQ      <= hangD;
    end
  end

  assign state      = stateQ;
  assign final_stat = finalStatQ;
  assign hang_flag  = hangQ;

  sat_counter #(.CNT_W(CNT_W)) uCycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .clr   (1'b0),
    .count (cycle_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) uRetire (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!halted && (W_stat == StatAok) && (W_icode != IcNop)),
    .clr   (1'b0),
    .count (retire_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) uStall (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!halted && F_stall),
    .clr   (1'b0),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) uBubble (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!halted && (D_bubble || E_bubble)),
    .clr   (1'b0),
    .count (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) uMispred (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!halted && misPred),
    .clr   (1'b0),
    .count (mispred_cnt)
  );

  // Watchdog run length; holds in DRAIN/HALTED while F_stall stays high.
  sat_counter #(.CNT_W(CNT_W)) uWatchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   ((stateQ == StRun) && F_stall),
    .clr   (!F_stall),
    .count (runCnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized scoreboard bench for pipe_hazard_ctrl against a behavioural reference model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W       = 8;
  localparam int unsigned STALL_LIMIT = 4;
  localparam int          SatMax      = (1 << CNT_W) - 1;
  localparam int          NumCycles   = 2000;

  logic             clk;
  logic             rst_n;
  logic [3:0]       D_icode, E_icode, E_dstM, M_icode, d_srcA, d_srcB, W_icode;
  logic             e_Cnd;
  logic [1:0]       m_stat, W_stat;
  logic             F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
  logic [1:0]       state, final_stat;
  logic             hang_flag;
  logic [CNT_W-1:0] cycle_cnt, retire_cnt, stall_cnt, bubble_cnt, mispred_cnt;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .STALL_LIMIT(STALL_LIMIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .D_icode     (D_icode),
    .E_icode     (E_icode),
    .E_dstM      (E_dstM),
    .M_icode     (M_icode),
    .d_srcA      (d_srcA),
    .d_srcB      (d_srcB),
    .e_Cnd       (e_Cnd),
    .m_stat      (m_stat),
    .W_stat      (W_stat),
    .W_icode     (W_icode),
    .F_stall     (F_stall),
    .D_stall     (D_stall),
    .D_bubble    (D_bubble),
    .E_bubble    (E_bubble),
    .M_bubble    (M_bubble),
    .W_stall     (W_stall),
    .set_cc      (set_cc),
    .state       (state),
    .final_stat  (final_stat),
    .hang_flag   (hang_flag),
    .cycle_cnt   (cycle_cnt),
    .retire_cnt  (retire_cnt),
    .stall_cnt   (stall_cnt),
    .bubble_cnt  (bubble_cnt),
    .mispred_cnt (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int fs, ds, db, eb, mb, ws, cc;
    int st, fin, hang;
    int cyc, ret, stl, bub, mis;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cycNum = 0;

  // Reference model state: 0=run, 1=drain, 2=halted
  int mState, mFinal, mHang, mRun, mCycle, mRetire, mStall, mBubble, mMispred;

  function automatic int sat(input int v);
    return (v > SatMax) ? SatMax : v;
  endfunction

  task automatic model_reset();
    mState = 0; mFinal = 0; mHang = 0; mRun = 0;
    mCycle = 0; mRetire = 0; mStall = 0; mBubble = 0; mMispred = 0;
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    bit lu, rp, mp, ex;
    lu = (E_icode == 4'd5 || E_icode == 4'd11) && E_dstM != 4'hF &&
         (E_dstM == d_srcA || E_dstM == d_srcB);
    rp = (D_icode == 4'd9) || (E_icode == 4'd9) || (M_icode == 4'd9);
    mp = (E_icode == 4'd7) && !e_Cnd;
    ex = (m_stat != 2'd0) || (W_stat != 2'd0);
    if (mState == 2) begin
      e.fs = 1; e.ds = 1; e.db = 0; e.eb = 1; e.mb = 1; e.ws = 1; e.cc = 0;
    end else begin
      e.fs = int'(lu || rp);
      e.ds = int'(lu);
      e.db = int'(mp || (rp && !lu));
      e.eb = int'(mp || lu);
      e.mb = int'(ex);
      e.ws = int'(W_stat != 2'd0);
      e.cc = int'(E_icode == 4'd6 && !ex);
    end
    e.st = mState; e.fin = mFinal; e.hang = mHang;
    e.cyc = mCycle; e.ret = mRetire; e.stl = mStall; e.bub = mBubble; e.mis = mMispred;
    return e;
  endfunction

  // Advance the model across one rising edge using the inputs held during that cycle.
  task automatic model_step();
    exp_t e;
    e = expect_now();
    mCycle = sat(mCycle + 1);
    if (mState != 2) begin
      if (W_stat == 2'd0 && W_icode != 4'd1) mRetire = sat(mRetire + 1);
      if (e.fs != 0) mStall = sat(mStall + 1);
      if (e.db != 0 || e.eb != 0) mBubble = sat(mBubble + 1);
      if (E_icode == 4'd7 && !e_Cnd) mMispred = sat(mMispred + 1);
    end
    if (mState == 0 && e.fs != 0) begin
      mRun = sat(mRun + 1);
      if (mRun >= STALL_LIMIT) mHang = 1;
    end else if (e.fs == 0) begin
      mRun = 0;
    end
    if (mState != 2 && W_stat != 2'd0) begin
      mState = 2;
      mFinal = int'(W_stat);
    end else if (mState == 0 && m_stat != 2'd0) begin
      mState = 1;
    end else if (mState == 1 && m_stat == 2'd0) begin
      mState = 0;
    end
  endtask

  task automatic drive_inputs(input bit holdLoadUse, input bit allowWErr);
    D_icode = 4'($urandom_range(0, 11));
    E_icode = 4'($urandom_range(0, 11));
    M_icode = 4'($urandom_range(0, 11));
    W_icode = 4'($urandom_range(0, 11));
    if ($urandom_range(0, 3) == 0) E_icode = 4'd5;
    E_dstM  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
    d_srcA  = 4'($urandom_range(0, 15));
    d_srcB  = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 2) == 0) d_srcA = E_dstM;
    e_Cnd   = 1'($urandom_range(0, 1));
    m_stat  = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    W_stat  = (allowWErr && $urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    if (holdLoadUse) begin
      E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3; m_stat = 2'd0; W_stat = 2'd0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cycNum, act, exp);
    end
  endtask

  // Monitor: outputs are settled mid-cycle, so compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("F_stall", 32'(F_stall), e.fs);
        chk("D_stall", 32'(D_stall), e.ds);
        chk("D_bubble", 32'(D_bubble), e.db);
        chk("E_bubble", 32'(E_bubble), e.eb);
        chk("M_bubble", 32'(M_bubble), e.mb);
        chk("W_stall", 32'(W_stall), e.ws);
        chk("set_cc", 32'(set_cc), e.cc);
        chk("state", 32'(state), e.st);
        chk("final_stat", 32'(final_stat), e.fin);
        chk("hang_flag", 32'(hang_flag), e.hang);
        chk("cycle_cnt", 32'(cycle_cnt), e.cyc);
        chk("retire_cnt", 32'(retire_cnt), e.ret);
        chk("stall_cnt", 32'(stall_cnt), e.stl);
        chk("bubble_cnt", 32'(bubble_cnt), e.bub);
        chk("mispred_cnt", 32'(mispred_cnt), e.mis);
      end
    end
  end

  initial begin
    bit hold, wErr, nextRst;
    rst_n = 1'b0;
    drive_inputs(1'b0, 1'b0);
    model_reset();
    for (int c = 0; c < NumCycles; c++) begin
      @(posedge clk);
      #1;
      cycNum = c;
      if (rst_n) model_step();
      // Early window has no W faults and no resets so the 8-bit counters saturate.
      if (c < 3) nextRst = 1'b0;
      else if (c < 400) nextRst = 1'b1;
      else nextRst = ($urandom_range(0, 49) != 0);
      hold = ((c % 100) >= 50) && ((c % 100) < 57);
      wErr = (c >= 400);
      rst_n = nextRst;
      if (!rst_n) model_reset();
      drive_inputs(hold, wErr);
      sb.push_back(expect_now());
    end
    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit for the Y86-64 five-stage pipeline (F, D, E, M, W).
- Watches the decode, execute, memory and writeback stage registers and drives the per-stage stall/bubble controls and the condition-code write enable.
- Sequences exception shutdown through a RUN/DRAIN/HALTED state machine.
- Keeps saturating performance counters and a stall watchdog for debug and benches.

Parameters:
CNT_W, 32, width of each performance counter
STALL_LIMIT, 64, consecutive F_stall cycles before hang_flag asserts (must be 1 to 2^CNT_W-1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
D_icode  in  4  icode in the D register
E_icode  in  4  icode in the E register
E_dstM  in  4  dstM in the E register (0xF = none)
M_icode  in  4  icode in the M register
d_srcA  in  4  srcA computed in decode
d_srcB  in  4  srcB computed in decode
e_Cnd  in  1  branch/cmov condition from execute
m_stat  in  2  status leaving the memory stage
W_stat  in  2  status in the W register
W_icode  in  4  icode in the W register
F_stall  out  1  hold the F register (PC)
D_stall  out  1  hold the D register
D_bubble  out  1  load nop into the D register
E_bubble  out  1  load nop into the E register
M_bubble  out  1  load nop into the M register
W_stall  out  1  hold the W register
set_cc  out  1  condition-code write enable for execute
state  out  2  0=RUN, 1=DRAIN, 2=HALTED
final_stat  out  2  stat latched on entry to HALTED
hang_flag  out  1  sticky watchdog flag
cycle_cnt  out  CNT_W  cycles since reset
retire_cnt  out  CNT_W  instructions retired
stall_cnt  out  CNT_W  cycles with F_stall=1
bubble_cnt  out  CNT_W  cycles with D_bubble or E_bubble
mispred_cnt  out  CNT_W  mispredicted jumps

Behaviour:
- Encodings:
  - icode: HALT=0, NOP=1, CMOV=2, IRMOV=3, RMMOV=4, MRMOV=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSH=10, POP=11.
  - stat: AOK=0, HLT=1, ADR=2, INS=3.
- Hazard terms (combinational):
  - loaduse = E_icode in {MRMOV, POP} && E_dstM != 0xF && E_dstM in {d_srcA, d_srcB}.
  - retp = RET in {D_icode, E_icode, M_icode}.
  - mispred = E_icode == JXX && !e_Cnd.
  - exc = m_stat != AOK || W_stat != AOK.
- Outputs in RUN and DRAIN (combinational):
  - F_stall = loaduse | retp.
  - D_stall = loaduse.
  - D_bubble = mispred | (retp & !loaduse).
  - E_bubble = mispred | loaduse.
  - M_bubble = exc.
  - W_stall = W_stat != AOK.
  - set_cc = E_icode == OPQ && !exc.
- D_stall and D_bubble are never both 1. Load/use takes priority over ret.
- State transitions:
  - RUN -> DRAIN when m_stat != AOK.
  - RUN or DRAIN -> HALTED when W_stat != AOK. HALTED latches final_stat = W_stat.
  - DRAIN -> RUN when m_stat == AOK and W_stat == AOK (the faulting instruction was squashed by an older mispredict).
  - HALTED is sticky until reset.
- In HALTED: F_stall=1, D_stall=1, W_stall=1, E_bubble=1, M_bubble=1, D_bubble=0, set_cc=0. Only cycle_cnt keeps counting.
- Counters:
  - Width CNT_W, saturate at all-ones, no wrap.
  - cycle_cnt increments every cycle.
  - retire_cnt increments when W_stat == AOK && W_icode != NOP && state != HALTED.
  - stall_cnt, bubble_cnt and mispred_cnt increment on their terms while not HALTED.
- Watchdog:
  - A run counter increments while F_stall=1 in RUN and clears when F_stall=0.
  - When it reaches STALL_LIMIT, hang_flag sets, sticky until reset.
  - Never set in HALTED.
- Reset (async assert, sync-safe deassert): state=RUN, final_stat=AOK, hang_flag=0, all counters=0.
  - During reset, outputs follow the RUN equations on the current inputs.
  - Reset asserted mid-drain or while halted returns the block to RUN immediately.
- Latency: control outputs are same-cycle combinational. State, counters and flags update on the next rising edge.

Decomposition:
- Package y86_pkg: icode constants, stat constants, state enum (RUN/DRAIN/HALTED), REG_NONE=0xF.
- One natural sub-module: sat_counter (CNT_W, inc, clk, rst_n -> count), instantiated five times plus one for the watchdog.

Test Plan:
- Load/use: E_icode=MRMOV, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. stall_cnt and bubble_cnt go 0->1 after the edge.
- Mispredict: E_icode=JXX, e_Cnd=0, D_icode=OPQ -> D_bubble=1, E_bubble=1, F_stall=0. mispred_cnt=1 next cycle.
- Ret: RET walked D->E->M over 3 cycles -> F_stall=1 and D_bubble=1 each cycle. Cycle 4 (RET in W) -> all controls 0. stall_cnt=3.
- Mispredict with RET in D: E_icode=JXX, e_Cnd=0, D_icode=RET -> F_stall=1, D_bubble=1, E_bubble=1.
- Exception: m_stat=ADR with E_icode=OPQ -> set_cc=0, M_bubble=1, state=DRAIN next cycle. Then W_stat=ADR -> W_stall=1, state=HALTED, final_stat=2, retire_cnt frozen, cycle_cnt still counting.
- Watchdog/reset: STALL_LIMIT=4, loaduse held 4 cycles -> hang_flag=1. Pulse rst_n=0 mid-cycle -> state=0, all counters 0, hang_flag=0 immediately (asynchronous).
